// File: rtl/serializer_gearbox_pkg.sv
// Shared types for the serializer gearbox: FSM state encodings and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_pkg;

  // IDLE: no active word; RUN: slice index cnt of the active word is on data_out
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Slice index width; at least one bit so the counter is never zero-width
  function automatic int cnt_width(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/serializer_gearbox_if.sv
// Word-in / slice-out bus of the serializer gearbox.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the word side; the slice side cannot be stalled.
interface serializer_gearbox_if #(
  parameter int D = 8,
  parameter int S = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [D*S-1:0] data_in;
  logic           msb_first;
  logic [D-1:0]   data_out;
  logic           out_valid;
  logic           out_last;
  logic           out_underrun;

  // Word producer / slice consumer side
  modport master (
    output in_valid, data_in, msb_first,
    input  in_ready, data_out, out_valid, out_last, out_underrun
  );

  // Serializer side
  modport slave (
    input  in_valid, data_in, msb_first,
    output in_ready, data_out, out_valid, out_last, out_underrun
  );
endinterface

// File: rtl/serializer_gearbox_slice_select.sv
// Picks slice i_idx out of a D*S word, counting from the LSB or the MSB end.
// Latency: purely combinational.
// Backpressure: none.
module serializer_slice_select
  import ddr_pkg::*;
#(
  parameter int D  = 8,
  parameter int S  = 4,
  parameter int CW = cnt_width(S)
) (
  input  logic [D*S-1:0] i_word,
  input  logic [CW-1:0]  i_idx,
  input  logic           i_msb_first,
  output logic [D-1:0]   o_slice
);

  logic [CW-1:0] w_pos;

  // Physical slice position: mirrored index when the word goes out MSB first
  always_comb begin
    w_pos = i_msb_first ? (CW'(S - 1) - i_idx) : i_idx;
  end

  // Constant part-selects only, so out-of-range positions simply yield zero
  always_comb begin
    o_slice = '0;
    for (int k = 0; k < S; k++) begin
      if (w_pos == CW'(k)) o_slice = i_word[k*D +: D];
    end
  end

endmodule

// File: rtl/serializer_gearbox.sv
// Serializes D*S-bit words into S consecutive D-bit slices through a one-entry pending buffer.
// Latency: word accepted at edge N into an idle block drives slice 0 after edge N+1.
// Backpressure: in_ready drops while a word is pending; output stream cannot be stalled.
module serializer_gearbox
  import ddr_pkg::*;
#(
  parameter int           D            = 8,
  parameter int           S            = 4,
  parameter logic [D-1:0] IDLE_PATTERN = '0
) (
  input  logic                 high_speed_clock,
  input  logic                 reset,
  serializer_gearbox_if.slave  bus
);

  localparam int            CW     = cnt_width(S);
  localparam logic [CW-1:0] C_LAST = CW'(S - 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [D*S-1:0] r_act_word;
  logic           r_act_msb;
  logic [D*S-1:0] r_pend_word;
  logic           r_pend_msb;
  logic           r_pend_valid;
  logic [D-1:0]   r_data_out;
  logic           r_out_valid;
  logic           r_out_last;
  logic           r_out_underrun;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_advance;
  logic [CW-1:0]  w_cnt_inc;
  logic [D*S-1:0] w_sel_word;
  logic [CW-1:0]  w_sel_idx;
  logic           w_sel_msb;
  logic [D-1:0]   w_slice;

  // The pending slot is the only storage for incoming words, so ready is just "slot empty"
  assign w_in_ready = !r_pend_valid && !reset;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_advance  = (r_state == ST_RUN) && (r_cnt != C_LAST);
  assign w_cnt_inc  = r_cnt + 1'b1;

  // One selector serves both cases: next slice of the active word, or slice 0 of the pending word
  always_comb begin
    w_sel_word = r_pend_word;
    w_sel_idx  = '0;
    w_sel_msb  = r_pend_msb;
    if (w_advance) begin
      w_sel_word = r_act_word;
      w_sel_idx  = w_cnt_inc;
      w_sel_msb  = r_act_msb;
    end
  end

  serializer_slice_select #(
    .D  (D),
    .S  (S),
    .CW (CW)
  ) u_slice_select (
    .i_word      (w_sel_word),
    .i_idx       (w_sel_idx),
    .i_msb_first (w_sel_msb),
    .o_slice     (w_slice)
  );

  // Pending-buffer fill plus the IDLE/RUN machine with registered slice outputs;
  // a fill (needs empty slot) and a drain (needs full slot) can never coincide
  always_ff @(posedge high_speed_clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_act_word     <= '0;
      r_act_msb      <= 1'b0;
      r_pend_word    <= '0;
      r_pend_msb     <= 1'b0;
      r_pend_valid   <= 1'b0;
      r_data_out     <= IDLE_PATTERN;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_underrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_word  <= bus.data_in;
        r_pend_msb   <= bus.msb_first;
        r_pend_valid <= 1'b1;
      end
      r_out_underrun <= 1'b0;
      if (w_advance) begin
        r_cnt      <= w_cnt_inc;
        r_data_out <= w_slice;
        r_out_last <= (w_cnt_inc == C_LAST);
      end else if (r_pend_valid) begin
        // Word boundary with a successor waiting: chain it with no gap
        r_state      <= ST_RUN;
        r_cnt        <= '0;
        r_act_word   <= r_pend_word;
        r_act_msb    <= r_pend_msb;
        r_pend_valid <= 1'b0;
        r_data_out   <= w_slice;
        r_out_valid  <= 1'b1;
        r_out_last   <= 1'b0;
      end else begin
        // Nothing to send: flag starvation only when a stream was actually running
        r_state        <= ST_IDLE;
        r_cnt          <= '0;
        r_data_out     <= IDLE_PATTERN;
        r_out_valid    <= 1'b0;
        r_out_last     <= 1'b0;
        r_out_underrun <= (r_state == ST_RUN);
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.data_out     = r_data_out;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_last     = r_out_last;
  assign bus.out_underrun = r_out_underrun;

endmodule

// File: doc/serializer_gearbox.md
SERIALIZER_GEARBOX -- requirements
Module: serializer_gearbox

Interface
REQ-001 Parameter D, 8, slice (output) bitwidth in bits; D >= 1.
REQ-002 Parameter S, 4, serialization ratio in slices per word; S >= 2.
REQ-003 Parameter IDLE_PATTERN, {D{1'b0}}, value driven on data_out when no slice is valid.
REQ-004 Port high_speed_clock input 1: the only clock; all flops are rising-edge.
REQ-005 Port reset input 1: asynchronous, active-high reset.
REQ-006 Port in_valid input 1: data_in holds a word to accept.
REQ-007 Port in_ready output 1: the block can accept a word this cycle.
REQ-008 Port data_in input D*S: parallel word.
REQ-009 Port msb_first input 1: slice order for the word; sampled with the word.
REQ-010 Port data_out output D: registered serial slice.
REQ-011 Port out_valid output 1: data_out holds a word slice.
REQ-012 Port out_last output 1: data_out holds the final slice of its word.
REQ-013 Port out_underrun output 1: one-cycle pulse on stream starvation.

Function
REQ-014 A word is accepted on a rising edge where in_valid && in_ready; the word and msb_first are stored in a one-entry pending buffer (pend_valid set).
REQ-015 in_ready is combinational: !pend_valid && !reset.
REQ-016 The state machine has two states: IDLE (no active word) and RUN (slice index cnt of the active word is on data_out).
REQ-017 On an edge in RUN with cnt != S-1: cnt <= cnt+1; data_out <= slice(cnt+1).
REQ-018 On an edge in IDLE, or in RUN with cnt == S-1: if pend_valid, load the pending word as active, data_out <= slice(0), cnt <= 0, state RUN, pend_valid cleared.
REQ-019 Under the same condition with pend_valid clear: state IDLE, data_out <= IDLE_PATTERN, out_valid <= 0.
REQ-020 Slice k is data_in[k*D +: D] when the sampled msb_first = 0, and data_in[(S-1-k)*D +: D] when it = 1.
REQ-021 out_valid is 1 exactly in RUN; out_last = (state == RUN) && (cnt == S-1).
REQ-022 Latency: a word accepted at edge N into an IDLE block drives slice 0 after edge N+1.
REQ-023 Back-to-back words with in_valid held high produce a gapless stream: slice 0 of word n+1 follows slice S-1 of word n.
REQ-024 out_underrun pulses for one cycle on the RUN->IDLE transition; there is no pulse on reset or while staying in IDLE.
REQ-025 cnt is $clog2(S) bits wide and never exceeds S-1, including for non-power-of-two S.
REQ-026 Pending-buffer load and drain never occur on the same edge, because in_ready is low while pend_valid is set.

Reset
REQ-027 While reset is high, asynchronously: state IDLE, cnt 0, pend_valid 0, data_out IDLE_PATTERN, out_valid 0, out_last 0, out_underrun 0, in_ready 0.
REQ-028 Reset mid-word discards the active and pending words; no partial slices are emitted after release.
REQ-029 After reset deasserts, in_ready is 1 and the first word obeys REQ-022.

Structure
REQ-030 The state encodings (ST_IDLE, ST_RUN) reside in shared package ddr_pkg.
REQ-031 Slice selection (word, index, order -> slice) is one sub-module, serializer_slice_select, which is purely combinational.
REQ-032 The design has no latches, and reset is the only asynchronous input.

Verification (D=8, S=4)
REQ-033 Single word 0x44332211, msb_first=0 -> data_out 0x11,0x22,0x33,0x44 on consecutive cycles; out_last with 0x44; out_underrun pulse on the following cycle, then data_out 0x00 and out_valid 0.
REQ-034 Same word, msb_first=1 -> data_out 0x44,0x33,0x22,0x11.
REQ-035 Three words 0xA3A2A1A0, 0xB3B2B1B0, 0xC3C2C1C0 offered continuously -> 12 consecutive valid slices with no gap; a single underrun pulse after 0xC3.
REQ-036 Reset asserted asynchronously (between clock edges) while slice 0x22 is on data_out and a word is pending -> data_out 0x00, out_valid 0, in_ready 0 immediately; after release nothing is emitted until a new word is accepted.
REQ-037 in_valid held with in_ready low -> the word is not accepted and the held word 0x55667788 is emitted exactly once.
REQ-038 S=3, D=4 build, word 0xCBA -> slices 0xA,0xB,0xC and cnt never reaches 3.
